// File: rtl/tdm_demultiplexer.sv
// Receive end of the 4-channel TDM link: serial bits in, four
// WIDTH-bit channel words out once per complete frame.
module tdm_demultiplexer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             sync,
  input  logic             din,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             address0,
  output logic             address1,
  output logic             frame_valid,
  output logic             sync_error
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    HUNT,
    RECEIVE,
    FRAME_START
  } state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] stage0;
  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;

  logic             restart;
  logic             take;
  logic             err;
  logic [WIDTH-1:0] base;
  logic [1:0]       cur_slot;
  logic [CW-1:0]    cur_cnt;
  logic [WIDTH-1:0] word;
  logic             last;

  // A sync bit (or any bit outside RECEIVE) starts a fresh slot 0.
  assign restart  = (state != RECEIVE) || sync;
  assign take     = bit_valid && ((state == RECEIVE) || sync);
  assign err      = bit_valid &&
                    (((state == RECEIVE) && sync) ||
                     ((state == FRAME_START) && !sync));
  assign base     = restart ? '0 : shreg;
  assign cur_slot = restart ? 2'd0 : slot;
  assign cur_cnt  = restart ? '0 : bitcnt;
  assign word     = (base << 1) | WIDTH'(din);
  assign last     = (cur_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      slot        <= 2'd0;
      bitcnt      <= '0;
      shreg       <= '0;
      stage0      <= '0;
      stage1      <= '0;
      stage2      <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      address0    <= 1'b0;
      address1    <= 1'b0;
      frame_valid <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_error  <= err;
      if (bit_valid && (state == FRAME_START) && !sync)
        state <= HUNT;
      if (take) begin
        if (last) begin
          bitcnt <= '0;
          shreg  <= '0;
          case (cur_slot)
            2'd0: stage0 <= word;
            2'd1: stage1 <= word;
            2'd2: stage2 <= word;
            default: begin
              out0        <= stage0;
              out1        <= stage1;
              out2        <= stage2;
              out3        <= word;
              frame_valid <= 1'b1;
            end
          endcase
          if (cur_slot == 2'd3) begin
            state                <= FRAME_START;
            slot                 <= 2'd0;
            {address1, address0} <= 2'd0;
          end else begin
            state                <= RECEIVE;
            slot                 <= cur_slot + 2'd1;
            {address1, address0} <= cur_slot + 2'd1;
          end
        end else begin
          state                <= RECEIVE;
          shreg                <= word;
          bitcnt               <= cur_cnt + CW'(1);
          slot                 <= cur_slot;
          {address1, address0} <= cur_slot;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Scoreboard bench for tdm_demultiplexer: expected frames are queued
// as stimulus is driven and compared on each frame_valid pulse.
module tb_tdm_demultiplexer;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_valid;
  logic       sync;
  logic       din;
  logic [3:0] out0;
  logic [3:0] out1;
  logic [3:0] out2;
  logic [3:0] out3;
  logic       address0;
  logic       address1;
  logic       frame_valid;
  logic       sync_error;

  always #5 clk = ~clk;

  tdm_demultiplexer #(.WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .bit_valid(bit_valid),
    .sync(sync),
    .din(din),
    .out0(out0),
    .out1(out1),
    .out2(out2),
    .out3(out3),
    .address0(address0),
    .address1(address1),
    .frame_valid(frame_valid),
    .sync_error(sync_error)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] sb[$];
  int          fv_cyc[$];
  int          err_seen = 0;
  int          exp_err = 0;
  int          fv_count = 0;
  int          cyc = 0;
  bit          gaps = 0;
  bit          addr_chk = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid) begin
        fv_count++;
        fv_cyc.push_back(cyc);
        if (sb.size() == 0)
          check("fv_unexpected", 1, 0);
        else
          check("frame", {out0, out1, out2, out3}, sb.pop_front());
      end
      if (sync_error) err_seen++;
      if (frame_valid && sync_error) check("fv_and_serr", 1, 0);
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      sync = 1'($urandom_range(0, 1));
      din  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(logic s, logic d);
    @(negedge clk);
    bit_valid = 1'b1;
    sync = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  // Frame word is {slot0,slot1,slot2,slot3}; bit i of the stream is w[15-i].
  task automatic send_bits(logic [15:0] w, int first, int n);
    for (int i = first; i < first + n; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      if (addr_chk) check("addr", {address1, address0}, 32'(i / 4));
      send_bit(i == 0, w[15-i]);
    end
  endtask

  task automatic send_frame(logic [15:0] w);
    send_bits(w, 0, 16);
    sb.push_back(w);
  endtask

  initial begin
    reset = 1'b1;
    bit_valid = 1'b0;
    sync = 1'b0;
    din = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {out0, out1, out2, out3}, 16'h0);
    check("rst_fv", frame_valid, 0);
    check("rst_serr", sync_error, 0);
    check("rst_addr", {address1, address0}, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // T1: contiguous frame, pulse right after the 16th bit
    send_frame(16'hA5F3);
    check("t1_fv", frame_valid, 1);
    check("t1_out", {out0, out1, out2, out3}, 16'hA5F3);
    idle(1);
    check("t1_fv_1cyc", frame_valid, 0);

    // T2: random bit_valid gaps, address tracks slot
    gaps = 1;
    addr_chk = 1;
    send_frame(16'hA5F3);
    check("t2_fv", frame_valid, 1);
    gaps = 0;
    addr_chk = 0;
    idle(1);

    // T3: sync reasserted at bit 6 restarts the frame
    send_bits(16'h9999, 0, 6);
    check("t3_hold_pre", {out0, out1, out2, out3}, 16'hA5F3);
    send_bits(16'h1234, 0, 1);
    exp_err++;
    check("t3_serr", sync_error, 1);
    check("t3_hold", {out0, out1, out2, out3}, 16'hA5F3);
    send_bits(16'h1234, 1, 15);
    sb.push_back(16'h1234);
    check("t3_out", {out0, out1, out2, out3}, 16'h1234);
    idle(1);

    // T4: back-to-back frames, pulses 16 cycles apart
    send_frame(16'hCCCC);
    send_frame(16'h0123);
    idle(1);
    check("t4_gap", 32'(fv_cyc[fv_cyc.size()-1] - fv_cyc[fv_cyc.size()-2]), 16);

    // T5: non-sync bit after frame end -> error, HUNT, outputs hold
    send_frame(16'hCCCC);
    send_bits(16'h0000, 1, 1);
    exp_err++;
    check("t5_serr", sync_error, 1);
    send_bits(16'hFFFF, 1, 5);
    check("t5_hunt_noerr", sync_error, 0);
    check("t5_hold", {out0, out1, out2, out3}, 16'hCCCC);
    send_frame(16'h7896);
    idle(1);

    // T6: async reset in slot 2, then a clean frame
    send_bits(16'hBEEF, 0, 10);
    check("t6_addr_pre", {address1, address0}, 2);
    #3 reset = 1'b1;
    #1;
    check("t6_out", {out0, out1, out2, out3}, 16'h0);
    check("t6_addr", {address1, address0}, 0);
    check("t6_fv", frame_valid, 0);
    @(negedge clk);
    bit_valid = 1'b0;
    reset = 1'b0;
    idle(1);
    send_frame(16'hBEEF);
    check("t6_out2", {out0, out1, out2, out3}, 16'hBEEF);
    idle(2);

    check("err_count", err_seen, exp_err);
    check("fv_count", fv_count, 8);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
